// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: loads win, ALU writes queue in order.
// Optional bypass lookup port enabled by defining WB_FWD_EN.
module wb_port_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 2
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              alu_wr_valid,
    input  logic [ADDR_W-1:0] alu_wr_addr,
    input  logic [DATA_W-1:0] alu_wr_data,
    output logic              alu_stall,
    input  logic              ld_wr_valid,
    input  logic [ADDR_W-1:0] ld_wr_addr,
    input  logic [DATA_W-1:0] ld_wr_data,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata
`ifdef WB_FWD_EN
    ,
    input  logic [ADDR_W-1:0] fwd_addr,
    output logic              fwd_hit,
    output logic [DATA_W-1:0] fwd_data
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] r_addr [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [DEPTH-1:0]  r_vld;
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;
    logic              r_we;
    logic [ADDR_W-1:0] r_waddr;
    logic [DATA_W-1:0] r_wdata;

    logic              w_ld;
    logic              w_full;
    logic              w_acc;
    logic              w_deq;
    logic              w_direct;
    logic              w_enq;
    logic              w_sel_we;
    logic              w_sel_upd;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_data;

    assign w_ld     = ld_wr_valid && (ld_wr_addr != '0);
    assign w_full   = (r_count == CNT_W'(DEPTH));
    assign w_acc    = alu_wr_valid && !w_full && (alu_wr_addr != '0);
    assign w_deq    = !w_ld && (r_count != '0);
    assign w_direct = !w_ld && (r_count == '0) && w_acc;
    assign w_enq    = w_acc && !w_direct;

    assign alu_stall = w_full;
    assign rf_we     = r_we;
    assign rf_waddr  = r_waddr;
    assign rf_wdata  = r_wdata;

    // Pick this cycle's write source: load, then buffer head, then ALU direct
    always_comb begin
        w_sel_we   = 1'b0;
        w_sel_upd  = 1'b0;
        w_sel_addr = r_waddr;
        w_sel_data = r_wdata;
        unique case (1'b1)
            w_ld: begin
                w_sel_we   = 1'b1;
                w_sel_upd  = 1'b1;
                w_sel_addr = ld_wr_addr;
                w_sel_data = ld_wr_data;
            end
            w_deq: begin
                w_sel_we   = r_vld[r_head];
                w_sel_upd  = r_vld[r_head];
                w_sel_addr = r_addr[r_head];
                w_sel_data = r_data[r_head];
            end
            w_direct: begin
                w_sel_we   = 1'b1;
                w_sel_upd  = 1'b1;
                w_sel_addr = alu_wr_addr;
                w_sel_data = alu_wr_data;
            end
            default: ;
        endcase
    end

    // Output register, pointers, occupancy and per-entry valid bits
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_vld   <= '0;
        end else begin
            r_we <= w_sel_we;
            if (w_sel_upd) begin
                r_waddr <= w_sel_addr;
                r_wdata <= w_sel_data;
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (w_ld && (r_addr[i] == ld_wr_addr)) begin
                    r_vld[i] <= 1'b0;
                end
            end
            if (w_deq) begin
                r_vld[r_head] <= 1'b0;
                r_head        <= r_head + PTR_W'(1);
            end
            if (w_enq) begin
                r_vld[r_tail] <= 1'b1;
                r_tail        <= r_tail + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_enq) - CNT_W'(w_deq);
        end
    end

    // Buffer payload; validity is tracked separately so no reset is needed
    always_ff @(posedge clock) begin
        if (w_enq) begin
            r_addr[r_tail] <= alu_wr_addr;
            r_data[r_tail] <= alu_wr_data;
        end
    end

`ifdef WB_FWD_EN
    logic [PTR_W-1:0] w_idx;

    // Bypass lookup: youngest valid buffered entry wins, else output stage
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        w_idx    = '0;
        if (r_we && (r_waddr == fwd_addr)) begin
            fwd_hit  = 1'b1;
            fwd_data = r_wdata;
        end
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = r_head + PTR_W'(i);
            if ((CNT_W'(i) < r_count) && r_vld[w_idx] &&
                (r_addr[w_idx] == fwd_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = r_data[w_idx];
            end
        end
        if (fwd_addr == '0) begin
            fwd_hit  = 1'b0;
            fwd_data = '0;
        end
    end
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: queue-based reference model, per-cycle
// compare on the falling edge, directed literal checks plus random traffic.
module tb_wb_port_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int DP = 2;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          alu_wr_valid = 1'b0;
    logic [AW-1:0] alu_wr_addr = '0;
    logic [DW-1:0] alu_wr_data = '0;
    logic          alu_stall;
    logic          ld_wr_valid = 1'b0;
    logic [AW-1:0] ld_wr_addr = '0;
    logic [DW-1:0] ld_wr_data = '0;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
`ifdef WB_FWD_EN
    logic [AW-1:0] fwd_addr = '0;
    logic          fwd_hit;
    logic [DW-1:0] fwd_data;
`endif

    wb_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DP)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .alu_wr_valid (alu_wr_valid),
        .alu_wr_addr  (alu_wr_addr),
        .alu_wr_data  (alu_wr_data),
        .alu_stall    (alu_stall),
        .ld_wr_valid  (ld_wr_valid),
        .ld_wr_addr   (ld_wr_addr),
        .ld_wr_data   (ld_wr_data),
        .rf_we        (rf_we),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata)
`ifdef WB_FWD_EN
        ,
        .fwd_addr     (fwd_addr),
        .fwd_hit      (fwd_hit),
        .fwd_data     (fwd_data)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        bit            v;
    } ent_t;

    ent_t          q[$];
    logic          m_we = 1'b0;
    logic [AW-1:0] m_waddr = '0;
    logic [DW-1:0] m_wdata = '0;
    bit            m_acc = 1'b0;
    int            vecs = 0;
    int            errs = 0;

    // Reference model: pending ALU writes as a queue of records
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            q.delete();
            m_we = 1'b0;
            m_waddr = '0;
            m_wdata = '0;
            m_acc = 1'b0;
        end else begin
            bit   ld;
            bit   direct;
            ent_t e;
            ld = ld_wr_valid && ld_wr_addr != 0;
            m_acc = alu_wr_valid && q.size() != DP;
            direct = 1'b0;
            if (ld) begin
                m_we = 1'b1;
                m_waddr = ld_wr_addr;
                m_wdata = ld_wr_data;
                foreach (q[i]) if (q[i].a == ld_wr_addr) q[i].v = 1'b0;
            end else if (q.size() > 0) begin
                e = q.pop_front();
                m_we = e.v;
                if (e.v) begin
                    m_waddr = e.a;
                    m_wdata = e.d;
                end
            end else if (m_acc && alu_wr_addr != 0) begin
                direct = 1'b1;
                m_we = 1'b1;
                m_waddr = alu_wr_addr;
                m_wdata = alu_wr_data;
            end else begin
                m_we = 1'b0;
            end
            if (m_acc && alu_wr_addr != 0 && !direct) begin
                e.a = alu_wr_addr;
                e.d = alu_wr_data;
                e.v = 1'b1;
                q.push_back(e);
            end
        end
    end

    // Per-cycle compare of every output against the model
    always @(negedge clock) begin
        bit stall_exp;
        stall_exp = (q.size() == DP);
        vecs++;
        if (rf_we !== m_we || rf_waddr !== m_waddr ||
            rf_wdata !== m_wdata || alu_stall !== stall_exp) begin
            errs++;
            $display("FAIL cycle t=%0t got we=%b a=%0d d=%h st=%b exp we=%b a=%0d d=%h st=%b",
                     $time, rf_we, rf_waddr, rf_wdata, alu_stall,
                     m_we, m_waddr, m_wdata, stall_exp);
        end
`ifdef WB_FWD_EN
        begin
            bit            h;
            logic [DW-1:0] d;
            h = 1'b0;
            d = '0;
            if (m_we && m_waddr == fwd_addr) begin
                h = 1'b1;
                d = m_wdata;
            end
            foreach (q[i]) if (q[i].v && q[i].a == fwd_addr) begin
                h = 1'b1;
                d = q[i].d;
            end
            if (fwd_addr == 0) begin
                h = 1'b0;
                d = '0;
            end
            vecs++;
            if (fwd_hit !== h || fwd_data !== d) begin
                errs++;
                $display("FAIL fwd t=%0t addr=%0d got %b/%h exp %b/%h",
                         $time, fwd_addr, fwd_hit, fwd_data, h, d);
            end
        end
`endif
    end

    task automatic lit(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got %h exp %h", nm, got, exp);
        end
    endtask

    task automatic cyc(input logic av, input logic [AW-1:0] aa,
                       input logic [DW-1:0] ad, input logic lv,
                       input logic [AW-1:0] la, input logic [DW-1:0] ldd);
        alu_wr_valid = av;
        alu_wr_addr  = aa;
        alu_wr_data  = ad;
        ld_wr_valid  = lv;
        ld_wr_addr   = la;
        ld_wr_data   = ldd;
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string nm, input logic we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic st);
        lit({nm, "_we"}, 64'(rf_we), 64'(we));
        if (we) begin
            lit({nm, "_addr"}, 64'(rf_waddr), 64'(a));
            lit({nm, "_data"}, 64'(rf_wdata), 64'(d));
        end
        lit({nm, "_stall"}, 64'(alu_stall), 64'(st));
    endtask

    initial begin
        #12;
        lit("rst_we", 64'(rf_we), 64'd0);
        lit("rst_addr", 64'(rf_waddr), 64'd0);
        lit("rst_data", 64'(rf_wdata), 64'd0);
        lit("rst_stall", 64'(alu_stall), 64'd0);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        // ALU direct write with empty buffer
        cyc(1, 5, 32'h11, 0, 0, 0);  chk("direct", 1, 5, 32'h11, 0);
        cyc(0, 0, 0, 0, 0, 0);       chk("direct_idle", 0, 0, 0, 0);
        // Load wins, ALU deferred by one cycle
        cyc(1, 7, 32'h22, 1, 3, 32'hAA); chk("ld_first", 1, 3, 32'hAA, 0);
        cyc(0, 0, 0, 0, 0, 0);           chk("alu_after", 1, 7, 32'h22, 0);
        cyc(0, 0, 0, 0, 0, 0);           chk("drained", 0, 0, 0, 0);
        // Three loads starve the buffer; r4 held by stall
        cyc(1, 1, 32'h101, 1, 10, 32'hA0); chk("s1", 1, 10, 32'hA0, 0);
        cyc(1, 2, 32'h102, 1, 11, 32'hA1); chk("s2", 1, 11, 32'hA1, 1);
        cyc(1, 4, 32'h104, 1, 12, 32'hA2); chk("s3", 1, 12, 32'hA2, 1);
        cyc(1, 4, 32'h104, 0, 0, 0);       chk("s4", 1, 1, 32'h101, 0);
        cyc(1, 4, 32'h104, 0, 0, 0);       chk("s5", 1, 2, 32'h102, 0);
        cyc(0, 0, 0, 0, 0, 0);             chk("s6", 1, 4, 32'h104, 0);
        cyc(0, 0, 0, 0, 0, 0);             chk("s7", 0, 0, 0, 0);
        // Squash of a buffered entry by a later load
        cyc(1, 9, 32'h1, 1, 20, 32'h3); chk("sq1", 1, 20, 32'h3, 0);
        cyc(0, 0, 0, 1, 9, 32'h2);      chk("sq2", 1, 9, 32'h2, 0);
        cyc(0, 0, 0, 0, 0, 0);          chk("sq3", 0, 0, 0, 0);
        lit("sq3_addr", 64'(rf_waddr), 64'd9);
        lit("sq3_data", 64'(rf_wdata), 64'h2);
        // Register zero on both paths
        cyc(1, 0, 32'h55, 1, 0, 32'h66); chk("r0", 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);           chk("r0_idle", 0, 0, 0, 0);
        // Fill with two r6 writes, then reset while full
        cyc(1, 6, 32'h5, 1, 21, 32'h7); chk("f1", 1, 21, 32'h7, 0);
        cyc(1, 6, 32'h9, 1, 22, 32'h8); chk("f2", 1, 22, 32'h8, 1);
        alu_wr_valid = 1'b0;
        ld_wr_valid  = 1'b0;
`ifdef WB_FWD_EN
        fwd_addr = 6;
        #1;
        lit("fwd_hit", 64'(fwd_hit), 64'd1);
        lit("fwd_data", 64'(fwd_data), 64'h9);
        fwd_addr = 0;
`endif
        reset_n = 1'b0;
        #1;
        lit("mid_rst_we", 64'(rf_we), 64'd0);
        lit("mid_rst_stall", 64'(alu_stall), 64'd0);
        lit("mid_rst_addr", 64'(rf_waddr), 64'd0);
        @(posedge clock);
        #2;
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        chk("post_rst", 0, 0, 0, 0);
        // Random traffic; upstream holds a stalled request
        for (int n = 0; n < 3000; n++) begin
            if (!(alu_wr_valid && !m_acc)) begin
                alu_wr_valid = ($urandom_range(0, 99) < 60);
                alu_wr_addr  = AW'($urandom_range(0, 7));
                alu_wr_data  = $urandom;
            end
            ld_wr_valid = ($urandom_range(0, 99) < 35);
            ld_wr_addr  = AW'($urandom_range(0, 7));
            ld_wr_data  = $urandom;
`ifdef WB_FWD_EN
            fwd_addr = AW'($urandom_range(0, 7));
`endif
            @(posedge clock);
            #1;
        end
        alu_wr_valid = 1'b0;
        ld_wr_valid  = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
